// File: rtl/mips_pkg.sv
// mips_pkg: shared decode constants, widths and the next-PC select encoding
// for the MIPS pipeline.
//   DEFAULT_RESET_PC : PC presented by fetch and ID after reset
//   OP_* / FN_*      : opcode and funct field values decoded in ID
//   npc_sel_e        : source selected for the next fetch PC
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_NUM    = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] FN_JR      = 6'h08;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_BR,
        NPC_J,
        NPC_JR,
        NPC_SEQ
    } npc_sel_e;

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: groups the fetch, forwarding, writeback and ID/EX-facing
// signals of the decode stage.
//   master : pipeline side (fetch, hazard unit, WB, ID/EX register)
//   slave  : the decode stage itself
interface id_stage_if;
    import mips_pkg::*;

    logic [XLEN-1:0]       if_pc;
    logic [XLEN-1:0]       if_instr;
    logic                  stall;
    logic                  fwd_rs_en;
    logic [XLEN-1:0]       fwd_rs_data;
    logic                  fwd_rt_en;
    logic [XLEN-1:0]       fwd_rt_data;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic [XLEN-1:0]       wb_pc;
    logic [XLEN-1:0]       npc;
    logic [XLEN-1:0]       id_pc;
    logic [XLEN-1:0]       id_instr;
    logic [XLEN-1:0]       rs_data;
    logic [XLEN-1:0]       rt_data;
    logic [XLEN-1:0]       imm_ext;
    logic [XLEN-1:0]       link_pc;
    logic                  id_bubble;

    modport master (
        output if_pc, if_instr, stall,
        output fwd_rs_en, fwd_rs_data, fwd_rt_en, fwd_rt_data,
        output wb_we, wb_addr, wb_data, wb_pc,
        input  npc, id_pc, id_instr, rs_data, rt_data, imm_ext, link_pc, id_bubble
    );

    modport slave (
        input  if_pc, if_instr, stall,
        input  fwd_rs_en, fwd_rs_data, fwd_rt_en, fwd_rt_data,
        input  wb_we, wb_addr, wb_data, wb_pc,
        output npc, id_pc, id_instr, rs_data, rt_data, imm_ext, link_pc, id_bubble
    );

endinterface

// File: rtl/grf.sv
// grf: 32x32 general register file, entry 0 hardwired to zero.
//   clk, reset      : clock, synchronous active-high clear of all entries
//   we, waddr, wdata: write port, effective on the rising edge
//   wpc             : PC of the writing instruction (trace only)
//   raddr_a/b       : combinational read addresses
//   rdata_a/b       : read data with write-through from the write port
// Optional: GRF_TRACE_EN prints every write request, index 0 included.
module grf
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = REG_NUM
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [XLEN-1:0]       wpc,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [XLEN-1:0]       rdata_a,
    output logic [XLEN-1:0]       rdata_b
);

    logic [XLEN-1:0] regs [DEPTH];

    // Write port; index 0 is never stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports: a same-cycle write is visible immediately.
    always_comb begin
        rdata_a = '0;
        if (raddr_a != '0) begin
            rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (raddr_b != '0) begin
            rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
        end
    end

`ifdef GRF_TRACE_EN
    // Grading trace; index 0 writes are reported too.
    always_ff @(posedge clk) begin
        if (!reset && we) begin
            $display("%d@%h: $%d <= %h", $time, wpc, waddr, wdata);
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^wpc;
`endif

endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage of the 5-stage MIPS pipeline.
//   clk, reset : clock, synchronous active-high reset
//   bus        : id_stage_if.slave carrying fetch inputs, stall, forwarding,
//                GRF writeback, the next-PC back to fetch and the decoded
//                operands towards ID/EX.
// Holds the IF/ID register and the GRF, resolves beq/bne/j/jal/jr with one
// delay slot (no flush). Optional: GRF_TRACE_EN enables the GRF write trace.
module id_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     REG_CNT  = REG_NUM
) (
    input  logic     clk,
    input  logic     reset,
    id_stage_if.slave bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;

    // IF/ID register; stall freezes it, reset overrides stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else if (!bus.stall) begin
            pc_q    <= bus.if_pc;
            instr_q <= bus.if_instr;
        end
    end

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs_idx;
    logic [REG_ADDR_W-1:0] rt_idx;
    logic [15:0]           imm16;
    logic [25:0]           index26;

    assign opcode  = instr_q[31:26];
    assign rs_idx  = instr_q[25:21];
    assign rt_idx  = instr_q[20:16];
    assign imm16   = instr_q[15:0];
    assign index26 = instr_q[25:0];
    assign funct   = instr_q[5:0];

    logic [XLEN-1:0] grf_rs;
    logic [XLEN-1:0] grf_rt;

    grf #(.DEPTH(REG_CNT)) u_grf (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.wb_we),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .wpc     (bus.wb_pc),
        .raddr_a (rs_idx),
        .raddr_b (rt_idx),
        .rdata_a (grf_rs),
        .rdata_b (grf_rt)
    );

    // Forwarded values take precedence over the register file.
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    assign rs_val = bus.fwd_rs_en ? bus.fwd_rs_data : grf_rs;
    assign rt_val = bus.fwd_rt_en ? bus.fwd_rt_data : grf_rt;

    // Immediate extension.
    logic [XLEN-1:0] sext_imm;
    logic [XLEN-1:0] imm_val;

    assign sext_imm = {{16{imm16[15]}}, imm16};

    always_comb begin
        imm_val = sext_imm;
        case (opcode)
            OP_ANDI, OP_ORI, OP_XORI: imm_val = {16'h0000, imm16};
            OP_LUI:                   imm_val = {imm16, 16'h0000};
            default:                  imm_val = sext_imm;
        endcase
    end

    // Branch/jump resolution; all sums wrap modulo 2^32.
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] j_target;
    logic            ops_equal;
    npc_sel_e        npc_sel;

    assign seq_pc    = bus.if_pc + XLEN'(4);
    assign br_target = pc_q + XLEN'(4) + {sext_imm[29:0], 2'b00};
    assign j_target  = {pc_q[31:28], index26, 2'b00};
    assign ops_equal = (rs_val == rt_val);

    always_comb begin
        npc_sel = NPC_SEQ;
        if (bus.stall) begin
            npc_sel = NPC_HOLD;
        end else if (((opcode == OP_BEQ) && ops_equal) ||
                     ((opcode == OP_BNE) && !ops_equal)) begin
            npc_sel = NPC_BR;
        end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
            npc_sel = NPC_J;
        end else if ((opcode == OP_SPECIAL) && (funct == FN_JR)) begin
            npc_sel = NPC_JR;
        end
    end

    always_comb begin
        bus.npc = seq_pc;
        case (npc_sel)
            NPC_HOLD: bus.npc = bus.if_pc;
            NPC_BR:   bus.npc = br_target;
            NPC_J:    bus.npc = j_target;
            NPC_JR:   bus.npc = rs_val;
            default:  bus.npc = seq_pc;
        endcase
    end

    assign bus.id_pc     = pc_q;
    assign bus.id_instr  = instr_q;
    assign bus.rs_data   = rs_val;
    assign bus.rt_data   = rt_val;
    assign bus.imm_ext   = imm_val;
    assign bus.link_pc   = pc_q + XLEN'(8);
    assign bus.id_bubble = bus.stall;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed bench for id_stage. The bench plays the role of
// fetch, hazard unit and writeback; expected outputs are queued as each step
// is driven and drained/compared once the step has settled.
module tb_id_stage;
    import mips_pkg::*;

    logic clk;
    logic reset;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int S_NPC    = 0;
    localparam int S_PC     = 1;
    localparam int S_INSTR  = 2;
    localparam int S_RS     = 3;
    localparam int S_RT     = 4;
    localparam int S_IMM    = 5;
    localparam int S_LINK   = 6;
    localparam int S_BUBBLE = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   passed;
    int   failed;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            S_NPC:    return bus.npc;
            S_PC:     return bus.id_pc;
            S_INSTR:  return bus.id_instr;
            S_RS:     return bus.rs_data;
            S_RT:     return bus.rt_data;
            S_IMM:    return bus.imm_ext;
            S_LINK:   return bus.link_pc;
            default:  return {31'b0, bus.id_bubble};
        endcase
    endfunction

    task automatic expect_v(string tag, int sel, logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [31:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            total++;
            assert (o === e.val) passed++;
            else begin
                failed++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(logic [31:0] pc, logic [31:0] ins);
        bus.if_pc    = pc;
        bus.if_instr = ins;
    endtask

    task automatic wb(logic we, logic [4:0] addr, logic [31:0] data);
        bus.wb_we   = we;
        bus.wb_addr = addr;
        bus.wb_data = data;
        bus.wb_pc   = 32'h0000_4000;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        reset  = 1'b1;
        bus.stall       = 1'b0;
        bus.fwd_rs_en   = 1'b0;
        bus.fwd_rs_data = '0;
        bus.fwd_rt_en   = 1'b0;
        bus.fwd_rt_data = '0;
        wb(1'b0, 5'd0, 32'h0);
        fetch(32'h0000_3000, 32'h0);

        // Reset state
        tick();
        tick();
        expect_v("rst_pc",     S_PC,     32'h0000_3000);
        expect_v("rst_instr",  S_INSTR,  32'h0);
        expect_v("rst_npc",    S_NPC,    32'h0000_3004);
        expect_v("rst_rs",     S_RS,     32'h0);
        expect_v("rst_rt",     S_RT,     32'h0);
        expect_v("rst_bubble", S_BUBBLE, 32'h0);
        check();
        reset = 1'b0;

        // addu $0,$5,$0 into ID
        fetch(32'h0000_3004, 32'h00A0_0021);
        tick();
        expect_v("addu_pc", S_PC, 32'h0000_3004);
        check();

        // Write to $0 is dropped, even via write-through
        wb(1'b1, 5'd0, 32'h1234_5678);
        expect_v("wr0_rt", S_RT, 32'h0);
        expect_v("wr0_rs", S_RS, 32'h0);
        check();

        // Write-through of $5 in the same cycle; beq $1,$1,+3 in fetch
        wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        fetch(32'h0000_3008, 32'h1021_0003);
        expect_v("wt_rs",   S_RS,  32'hDEAD_BEEF);
        expect_v("wt_rt",   S_RT,  32'h0);
        expect_v("seq_npc", S_NPC, 32'h0000_300C);
        check();
        tick();

        // beq taken at 0x3008; delay slot reads $5
        wb(1'b0, 5'd0, 32'h0);
        fetch(32'h0000_300C, 32'h00A0_0021);
        expect_v("beq_pc",  S_PC,  32'h0000_3008);
        expect_v("beq_npc", S_NPC, 32'h0000_3018);
        expect_v("beq_imm", S_IMM, 32'h0000_0003);
        check();
        tick();

        // Delay slot latched; $5 now from the array
        fetch(32'h0000_3018, 32'h1421_0003);
        expect_v("ds_pc",    S_PC,    32'h0000_300C);
        expect_v("ds_instr", S_INSTR, 32'h00A0_0021);
        expect_v("ds_rs",    S_RS,    32'hDEAD_BEEF);
        expect_v("ds_npc",   S_NPC,   32'h0000_301C);
        check();
        tick();

        // bne $1,$1 not taken
        fetch(32'h0000_301C, 32'h10A0_0001);
        expect_v("bne_nt_npc", S_NPC, 32'h0000_3020);
        check();
        tick();

        // beq $5,$0 not taken
        fetch(32'h0000_3020, 32'h14A0_FFFE);
        expect_v("beq_nt_npc", S_NPC, 32'h0000_3024);
        check();
        tick();

        // bne $5,$0,-2 taken: backward offset
        fetch(32'h0000_3010, 32'h0C00_0C00);
        expect_v("bne_back_npc", S_NPC, 32'h0000_301C);
        expect_v("bne_back_imm", S_IMM, 32'hFFFF_FFFE);
        check();
        tick();

        // jal 0xC00 at 0x3010
        fetch(32'hA000_0000, 32'h0800_0010);
        expect_v("jal_npc",  S_NPC,  32'h0000_3000);
        expect_v("jal_link", S_LINK, 32'h0000_3018);
        check();
        tick();

        // j keeps upper PC bits
        fetch(32'hFFFF_FFFC, 32'h3401_8001);
        expect_v("j_hi_npc", S_NPC, 32'hA000_0040);
        check();
        tick();

        // ori zero-extends; link and sequential PC wrap
        fetch(32'hFFFF_FFFC, 32'h3C01_ABCD);
        expect_v("ori_imm",   S_IMM,  32'h0000_8001);
        expect_v("wrap_link", S_LINK, 32'h0000_0004);
        expect_v("wrap_npc",  S_NPC,  32'h0000_0000);
        check();
        tick();

        // lui
        fetch(32'h0000_3040, 32'h2001_8001);
        expect_v("lui_imm", S_IMM, 32'hABCD_0000);
        check();
        tick();

        // addi sign-extends
        fetch(32'h0000_3100, 32'h1000_FFFF);
        expect_v("addi_imm", S_IMM, 32'hFFFF_8001);
        check();
        tick();

        // Stall with taken beq $0,$0,-1 in ID; GRF write continues
        bus.stall = 1'b1;
        fetch(32'h0000_3104, 32'h03E0_0008);
        wb(1'b1, 5'd31, 32'h0000_1111);
        expect_v("st_npc",    S_NPC,    32'h0000_3104);
        expect_v("st_bubble", S_BUBBLE, 32'h1);
        check();
        tick();

        wb(1'b1, 5'd2, 32'h0000_0055);
        expect_v("st1_pc",    S_PC,     32'h0000_3100);
        expect_v("st1_instr", S_INSTR,  32'h1000_FFFF);
        expect_v("st1_npc",   S_NPC,    32'h0000_3104);
        expect_v("st1_bub",   S_BUBBLE, 32'h1);
        check();
        tick();

        // Release: branch resolves to itself
        wb(1'b0, 5'd0, 32'h0);
        bus.stall = 1'b0;
        expect_v("st2_pc",  S_PC,     32'h0000_3100);
        expect_v("rel_bub", S_BUBBLE, 32'h0);
        expect_v("rel_npc", S_NPC,    32'h0000_3100);
        check();
        tick();

        // jr $31 from GRF, then with forwarding
        expect_v("jr_pc",  S_PC,  32'h0000_3104);
        expect_v("jr_npc", S_NPC, 32'h0000_1111);
        check();
        bus.fwd_rs_en   = 1'b1;
        bus.fwd_rs_data = 32'h0000_3040;
        fetch(32'h0000_3108, 32'h005F_0021);
        expect_v("jr_fwd_npc", S_NPC, 32'h0000_3040);
        expect_v("jr_fwd_rs",  S_RS,  32'h0000_3040);
        check();
        tick();

        // rs=$2, rt=$31, then forwarded rt
        bus.fwd_rs_en = 1'b0;
        expect_v("rd2_rs",  S_RS, 32'h0000_0055);
        expect_v("rd31_rt", S_RT, 32'h0000_1111);
        check();
        bus.fwd_rt_en   = 1'b1;
        bus.fwd_rt_data = 32'hCAFE_0000;
        expect_v("fwd_rt", S_RT, 32'hCAFE_0000);
        check();

        // Reset during stall wins
        bus.stall = 1'b1;
        reset     = 1'b1;
        tick();
        expect_v("rs_st_pc",    S_PC,     32'h0000_3000);
        expect_v("rs_st_instr", S_INSTR,  32'h0);
        expect_v("rs_st_bub",   S_BUBBLE, 32'h1);
        expect_v("rs_st_npc",   S_NPC,    32'h0000_3108);
        check();

        // GRF cleared by reset
        reset         = 1'b0;
        bus.stall     = 1'b0;
        bus.fwd_rt_en = 1'b0;
        fetch(32'h0000_3000, 32'h005F_0021);
        tick();
        expect_v("clr_rs", S_RS, 32'h0);
        expect_v("clr_rt", S_RT, 32'h0);
        check();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
